// File: rtl/frame_pkg.sv
// Shared frame-buffer constants, arbiter state encoding and the pixel-to-RAM
// address mapping used by the frame write arbiter.
package frame_pkg;

  localparam int unsigned H_RES     = 640;
  localparam int unsigned V_RES     = 480;
  localparam int unsigned COORD_W   = 10;
  localparam int unsigned SUM_W     = 11;
  localparam int unsigned FB_ADDR_W = 19;
  localparam logic [4:0]  TRANSPARENT = 5'h15;

  typedef enum logic {IDLE, WRITE} state_e;

  // Linear address y*H_RES + ((x + scroll) mod H_RES); a single subtract
  // suffices because x and scroll are both below H_RES for on-screen pixels.
  function automatic logic [FB_ADDR_W-1:0] pix_addr(input logic [COORD_W-1:0] x,
                                                    input logic [COORD_W-1:0] y,
                                                    input logic [COORD_W-1:0] scroll);
    logic [SUM_W-1:0]     sum;
    logic [FB_ADDR_W-1:0] row;
    sum = SUM_W'(x) + SUM_W'(scroll);
    if (sum >= SUM_W'(H_RES)) begin
      sum = sum - SUM_W'(H_RES);
    end
    row = FB_ADDR_W'(y) * FB_ADDR_W'(H_RES);
    return row + FB_ADDR_W'(sum);
  endfunction

endpackage

// File: rtl/frame_write_arbiter_rr_picker.sv
// Combinational round-robin selector: first active request at or after ptr+1,
// wrapping modulo NUM_REQ.
module rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   index
);

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    onehot = '0;
    index  = '0;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found        = 1'b1;
        onehot[cand] = 1'b1;
        index        = cand;
      end
    end
  end

endmodule

// File: rtl/frame_write_arbiter.sv
// Round-robin arbiter for the frame RAM write port: grants during blanking,
// maps (x, y) to a scrolled linear address and drops transparent/off-screen pixels.
module frame_write_arbiter
  import frame_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PIX_W   = 5,
  parameter int unsigned ADDR_W  = 19,
  parameter int unsigned H_RES   = 640,
  parameter int unsigned V_RES   = 480,
  parameter logic [PIX_W-1:0] TRANSPARENT = 5'h15
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       blank,
  input  logic [COORD_W-1:0]         scroll_x,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*COORD_W-1:0] req_x,
  input  logic [NUM_REQ*COORD_W-1:0] req_y,
  input  logic [NUM_REQ*PIX_W-1:0]   req_pix,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       we,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [PIX_W-1:0]           wr_data,
  output logic                       busy,
  output logic [7:0]                 drop_cnt
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0]     wr_data_q, wr_data_d;
  logic                 busy_q, busy_d;
  logic [7:0]           drop_cnt_q, drop_cnt_d;

  logic [NUM_REQ-1:0]   pick_onehot;
  logic [IDX_W-1:0]     pick_idx;
  logic [COORD_W-1:0]   sel_x, sel_y;
  logic [PIX_W-1:0]     sel_pix;
  logic                 off_screen, transparent;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req    (req),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .index  (pick_idx)
  );

  // Route the winner's coordinates and pixel code.
  always_comb begin
    sel_x   = '0;
    sel_y   = '0;
    sel_pix = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_onehot[i]) begin
        sel_x   = req_x[i*COORD_W +: COORD_W];
        sel_y   = req_y[i*COORD_W +: COORD_W];
        sel_pix = req_pix[i*PIX_W +: PIX_W];
      end
    end
    off_screen  = (sel_x >= COORD_W'(H_RES)) || (sel_y >= COORD_W'(V_RES));
    transparent = (sel_pix == TRANSPARENT);
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = '0;
    we_d       = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    busy_d     = 1'b0;
    drop_cnt_d = drop_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (blank && (|req)) begin
          state_d   = WRITE;
          ptr_d     = pick_idx;
          gnt_d     = pick_onehot;
          busy_d    = 1'b1;
          wr_addr_d = ADDR_W'(pix_addr(sel_x, sel_y, scroll_x));
          wr_data_d = sel_pix;
          // Off-screen takes precedence over transparency for the drop count.
          if (off_screen) begin
            if (drop_cnt_q != 8'hFF) begin
              drop_cnt_d = drop_cnt_q + 8'd1;
            end
          end else if (!transparent) begin
            we_d = 1'b1;
          end
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      ptr_q      <= IDX_W'(NUM_REQ - 1);
      gnt_q      <= '0;
      we_q       <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign gnt      = gnt_q;
  assign we       = we_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_frame_write_arbiter.sv
// Directed bench for frame_write_arbiter: vector table for single grants plus
// sequences for reset, round-robin order, blanking and drop saturation.
module tb_frame_write_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 10;
  localparam int unsigned PW = 5;
  localparam int unsigned AW = 19;

  logic            clk;
  logic            rst_n;
  logic            blank;
  logic [CW-1:0]   scroll_x;
  logic [N-1:0]    req;
  logic [N*CW-1:0] req_x;
  logic [N*CW-1:0] req_y;
  logic [N*PW-1:0] req_pix;
  logic [N-1:0]    gnt;
  logic            we;
  logic [AW-1:0]   wr_addr;
  logic [PW-1:0]   wr_data;
  logic            busy;
  logic [7:0]      drop_cnt;

  int errors = 0;
  int checks = 0;
  int exp_drop = 0;

  frame_write_arbiter dut (
    .Clk      (clk),
    .Reset    (rst_n),
    .blank    (blank),
    .scroll_x (scroll_x),
    .req      (req),
    .req_x    (req_x),
    .req_y    (req_y),
    .req_pix  (req_pix),
    .gnt      (gnt),
    .we       (we),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int id;
    int x;
    int y;
    int pix;
    int scroll;
    bit exp_we;
    int exp_addr;
    bit off;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_req(input int id, input int x, input int y, input int pix);
    req = '0;
    req[id] = 1'b1;
    req_x[id*CW +: CW]   = CW'(x);
    req_y[id*CW +: CW]   = CW'(y);
    req_pix[id*PW +: PW] = PW'(pix);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, int'(gnt), 0);
    chk({tag, "_we"}, int'(we), 0);
    chk({tag, "_addr"}, int'(wr_addr), 0);
    chk({tag, "_data"}, int'(wr_data), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_drop"}, int'(drop_cnt), 0);
  endtask

  initial begin
    vec_t v;
    //             id  x    y    pix    scroll we  addr    off
    vecs[0] = '{1,  5,   2,   3,     0,   1'b1, 1285,   1'b0};
    vecs[1] = '{0,  630, 0,   7,     20,  1'b1, 10,     1'b0};
    vecs[2] = '{2,  10,  3,   'h15,  0,   1'b0, 0,      1'b0};
    vecs[3] = '{2,  700, 1,   1,     0,   1'b0, 0,      1'b1};
    vecs[4] = '{3,  639, 479, 31,    1,   1'b1, 306560, 1'b0};
    vecs[5] = '{3,  0,   480, 2,     0,   1'b0, 0,      1'b1};
    vecs[6] = '{0,  700, 0,   'h15,  0,   1'b0, 0,      1'b1};
    vecs[7] = '{1,  100, 10,  0,     639, 1'b1, 6499,   1'b0};

    rst_n = 1'b0; blank = 1'b0; scroll_x = '0;
    req = '0; req_x = '0; req_y = '0; req_pix = '0;
    @(negedge clk); @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    blank = 1'b1;

    // Single-requester grants from the vector table.
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      scroll_x = CW'(v.scroll);
      set_req(v.id, v.x, v.y, v.pix);
      @(negedge clk);
      if (v.off && exp_drop < 255) exp_drop++;
      chk($sformatf("v%0d_gnt", i), int'(gnt), 1 << v.id);
      chk($sformatf("v%0d_we", i), int'(we), int'(v.exp_we));
      chk($sformatf("v%0d_data", i), int'(wr_data), v.pix);
      chk($sformatf("v%0d_busy", i), int'(busy), 1);
      chk($sformatf("v%0d_drop", i), int'(drop_cnt), exp_drop);
      if (v.exp_we) chk($sformatf("v%0d_addr", i), int'(wr_addr), v.exp_addr);
      req = '0;
      @(negedge clk);
      chk($sformatf("v%0d_gnt_off", i), int'(gnt), 0);
      chk($sformatf("v%0d_busy_off", i), int'(busy), 0);
      chk($sformatf("v%0d_we_off", i), int'(we), 0);
    end

    // Reset during WRITE: outputs clear without a clock edge.
    scroll_x = '0;
    set_req(2, 1, 1, 4);
    @(negedge clk);
    chk("pre_rst_gnt", int'(gnt), 4);
    chk("pre_rst_we", int'(we), 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    exp_drop = 0;
    @(negedge clk);

    // All four request continuously; requester 0 must win first after reset.
    req = '1;
    for (int i = 0; i < 4; i++) begin
      req_x[i*CW +: CW]   = CW'(i);
      req_y[i*CW +: CW]   = '0;
      req_pix[i*PW +: PW] = PW'(1);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c % 2 == 0) begin
        chk($sformatf("rr%0d_gnt", c), int'(gnt), 1 << ((c / 2) % 4));
        chk($sformatf("rr%0d_addr", c), int'(wr_addr), (c / 2) % 4);
      end else begin
        chk($sformatf("rr%0d_gnt", c), int'(gnt), 0);
      end
    end
    req = '0;
    @(negedge clk);

    // No grants while blank is low.
    blank = 1'b0;
    set_req(1, 5, 5, 3);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("noblank%0d_gnt", c), int'(gnt), 0);
      chk($sformatf("noblank%0d_busy", c), int'(busy), 0);
    end

    // Blank falls right after a grant: that write still completes.
    blank = 1'b1;
    set_req(2, 20, 20, 6);
    @(negedge clk);
    blank = 1'b0;
    chk("bfall_gnt", int'(gnt), 4);
    chk("bfall_we", int'(we), 1);
    chk("bfall_addr", int'(wr_addr), 12820);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("bfall%0d_gnt", c), int'(gnt), 0);
    end
    blank = 1'b1;
    @(negedge clk);
    chk("brise_gnt", int'(gnt), 4);
    req = '0;
    @(negedge clk);

    // 300 off-screen requests saturate the drop counter at 255.
    set_req(0, 700, 0, 1);
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (exp_drop < 255) exp_drop++;
      if (n == 1 || n == 300) begin
        chk($sformatf("sat%0d_gnt", n), int'(gnt), 1);
        chk($sformatf("sat%0d_we", n), int'(we), 0);
      end
      if (n == 100 || n == 255 || n == 256 || n == 300)
        chk($sformatf("sat%0d_drop", n), int'(drop_cnt), exp_drop);
      @(negedge clk);
      if (n == 300) req = '0;
    end
    chk("sat_final", int'(drop_cnt), 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
